// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake stage states, the default NOP
// bubble value and the packed payload layouts used at each stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // All-zero payload decodes as a NOP in every downstream stage.
    localparam logic [63:0] NOP_BUBBLE = 64'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a main register and a one-entry skid
// register, so in_ready comes straight from state and never from out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_BUBBLE),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Anything accepted this cycle is dropped along with the contents.
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .clr   (1'b0),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, reset/saturation sequences
// and a randomized run against a queue-based reference model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [63:0] s_in_data = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [63:0] s_out_data;
    logic [2:0]  s_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(64), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        flush;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
        logic [15:0] e_st;
    } vec_t;

    vec_t tbl[17];

    logic [63:0] mq[$];
    int unsigned mstall;
    logic        m_ir, m_ov, ifire, ofire;
    logic        r_flush, r_iv, r_ordy;
    logic [63:0] r_d;
    logic [63:0] m_od;

    initial begin
        // Streaming 1..4, then back-pressure with A/B, then flush while in SKID.
        tbl[0]  = '{1'b0, 1'b1, 64'h1, 1'b1, 1'b1, 1'b1, 64'h1, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 64'h2, 1'b1, 1'b1, 1'b1, 64'h2, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 64'h3, 1'b1, 1'b1, 1'b1, 64'h3, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 64'h4, 1'b1, 1'b1, 1'b1, 64'h4, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 64'hA, 16'd0};
        tbl[6]  = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 64'hA, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 64'hD, 1'b0, 1'b0, 1'b1, 64'hA, 16'd2};
        tbl[8]  = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hA, 16'd3};
        tbl[9]  = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hA, 16'd4};
        tbl[10] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hA, 16'd5};
        tbl[11] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'hB, 16'd5};
        tbl[12] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 16'd5};
        tbl[13] = '{1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 64'hA, 16'd5};
        tbl[14] = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 64'hA, 16'd6};
        tbl[15] = '{1'b1, 1'b1, 64'hC, 1'b1, 1'b1, 1'b0, 64'h0, 16'd6};
        tbl[16] = '{1'b0, 1'b0, 64'hC, 1'b1, 1'b1, 1'b0, 64'h0, 16'd6};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_stall", {48'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            flush = tbl[i].flush;
            in_valid = tbl[i].iv;
            in_data = tbl[i].d;
            out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            $display("row %0d: flush=%0b in_valid=%0b in_data=%h out_ready=%0b -> in_ready=%0b out_valid=%0b out_data=%h stall=%0d",
                     i, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy, in_ready, out_valid, out_data, stall_cnt);
            chk($sformatf("row%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].e_ir});
            chk($sformatf("row%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
            chk($sformatf("row%0d_out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("row%0d_stall", i), {48'd0, stall_cnt}, {48'd0, tbl[i].e_st});
        end

        // Asynchronous reset in the middle of a held transfer
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h55;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_out_data", out_data, 64'h55);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset mid-transfer: in_ready=%0b out_valid=%0b out_data=%h stall=%0d",
                 in_ready, out_valid, out_data, stall_cnt);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_out_data", out_data, 64'd0);
        chk("async_rst_stall", {48'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation of a 3-bit stall counter
        s_in_valid = 1'b1;
        s_in_data = 64'h7;
        s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            $display("saturation cycle %0d: stall=%0d out_data=%h", i, s_stall, s_out_data);
            chk($sformatf("sat_stall_%0d", i), {61'd0, s_stall}, (i < 7) ? 64'(i) : 64'd7);
        end
        chk("sat_out_data_held", s_out_data, 64'h7);

        // Randomized run against a queue model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mstall = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            m_ir = (mq.size() < 2);
            m_ov = (mq.size() > 0);
            m_od = m_ov ? mq[0] : 64'd0;
            chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, m_ir});
            chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, m_ov});
            chk("rnd_out_data", out_data, m_od);
            chk("rnd_stall", {48'd0, stall_cnt}, 64'(mstall));
            r_iv = ($urandom_range(0, 9) < 7);
            r_ordy = ($urandom_range(0, 9) < 6);
            r_flush = ($urandom_range(0, 99) < 3);
            r_d = {$urandom, $urandom};
            in_valid = r_iv;
            in_data = r_d;
            flush = r_flush;
            out_ready = ~r_ordy;
            #1;
            if ((c % 16) == 0) begin
                chk("rnd_in_ready_indep", {63'd0, in_ready}, {63'd0, m_ir});
            end
            out_ready = r_ordy;
            @(posedge clk);
            ifire = r_iv && m_ir;
            ofire = m_ov && r_ordy;
            if (m_ov && !r_ordy && mstall < 65535) mstall++;
            if (r_flush) begin
                mq.delete();
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(r_d);
            end
        end
        $display("random run: 10000 cycles, %0d entries left in model", mq.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register, successor to the fixed 2×32-bit IF/ID latch.
- Replaces the en/clr pair with a valid/ready handshake and a 2-entry skid buffer, so upstream ready is a registered signal.
- Supports synchronous flush, which inserts a programmable bubble value.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, ...) with the stage payload packed into one bus.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {Instr, PCPlus4}).
- BUBBLE, {DATA_W{1'b0}}, value driven on out_data and loaded into storage on reset, flush, or empty (all-zero = NOP).
- CNT_W, 16, width of the saturating back-pressure stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; empties the stage.
- in_valid  in  1  upstream holds valid data.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main register holds valid data.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main register contents.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage: main register M, skid register S, and a state register.
- States:
  - EMPTY: M invalid.
  - FULL: M valid.
  - SKID: M and S valid.
- Outputs by state:
  - in_ready = (state != SKID).
  - out_valid = (state != EMPTY).
  - out_data = M; M always holds BUBBLE while EMPTY.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Transitions at posedge when flush=0:
  - EMPTY: in_fire -> FULL, M<=in_data.
  - FULL, in_fire & out_fire -> FULL, M<=in_data.
  - FULL, in_fire only -> SKID, S<=in_data.
  - FULL, out_fire only -> EMPTY, M<=BUBBLE.
  - FULL, neither -> hold.
  - SKID, out_fire -> FULL, M<=S, S<=BUBBLE.
  - SKID, otherwise -> hold; in_valid is ignored because in_ready=0.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid.
  - Full throughput of 1 transfer/cycle with out_ready held high.
- Data stability:
  - out_data and out_valid stay stable while out_valid & !out_ready.
  - No data is lost or duplicated under any in_valid/out_ready pattern.
- flush=1 has priority over all transitions:
  - Next state EMPTY; M<=BUBBLE, S<=BUBBLE.
  - A same-cycle in_fire is consumed and discarded.
  - A same-cycle out_fire counts as delivered.
  - stall_cnt is unaffected.
- rst=1, asynchronous, including mid-operation:
  - State EMPTY; M=S=BUBBLE.
  - in_ready=1, out_valid=0, out_data=BUBBLE, stall_cnt=0.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1, never wraps.
  - Cleared only by rst.
- No illegal state is reachable; an encoding outside the three states recovers to EMPTY.

Decomposition:
- Shared package pipe_pkg holds:
  - State enum {ST_EMPTY, ST_FULL, ST_SKID}.
  - Default NOP bubble constant.
  - Packed payload typedefs per stage boundary (if_id_t = {instr[31:0], pc_plus4[31:0]}).
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; output count), used for stall_cnt.

Test Plan:
- Reset/idle: assert rst mid-transfer with M valid -> immediately out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready constantly 1.
- Back-pressure: send 0xA, 0xB; out_ready=0 for 5 cycles -> state SKID, in_ready=0 from the cycle after 0xB is accepted, out_data holds 0xA, stall_cnt=5. Then out_ready=1 -> 0xA then 0xB delivered, in_ready returns 1.
- Flush: in SKID holding 0xA/0xB, pulse flush with in_valid=1 data 0xC -> next cycle out_valid=0, out_data=BUBBLE, 0xC never appears, stall_cnt unchanged.
- Saturation: CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt stops at 7.
- Random: random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> output order matches input minus flushed entries, and in_ready never depends combinationally on out_ready.
